stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Sequencer for the stopwatch's cascaded digit-counter chain. Debounces the two
//  DE0 push-buttons, runs a start/stop/lap/clear state machine, divides clk down to
//  one count-enable pulse per tick, drives the chain's active-low clear and a display-
//  freeze flag for lap mode, and latches a sticky overflow from the chain's top carry.
// PARAMETERS
//  DIV        500000  clk cycles per tick (50 MHz -> 100 Hz, 1/100 s digit); >= 2
//  DEB_CYCLES 250000  consecutive stable synced samples needed to accept a key level
//  PW         19      prescaler width; 2**PW >= DIV
//  DW         18      debounce counter width; 2**DW >= DEB_CYCLES
// PORTS
//  clk        in   1  system clock
//  nclr       in   1  async active-low reset
//  key_ss     in   1  raw start/stop button, active-low, asynchronous
//  key_lc     in   1  raw lap/clear button, active-low, asynchronous
//  chain_cout in   1  carry-out of the most-significant digit counter
//  cnt_en     out  1  cin to least-significant digit counter; 1-clk pulse per tick
//  cnt_nclr   out  1  active-low clear to all digit counters
//  disp_hold  out  1  1 = display latch frozen (lap shown), 0 = display follows chain
//  ovf        out  1  sticky: chain wrapped past its maximum since last clear
//  state      out  2  current FSM state (debug LEDs)
// BEHAVIOUR
//  Reset (nclr=0, async): state=IDLE, cnt_en=0, cnt_nclr=0, disp_hold=0, ovf=0,
//   prescaler=0, key synchronisers/debounced levels=1 (released), no press pulses.
//  Keys: 2-FF sync -> debounce (level accepted after DEB_CYCLES equal samples) ->
//   press = 1-clk pulse on debounced 1->0. Release generates nothing. Held key = one press.
//  States (IDLE=0, RUN=1, STOP=2, LAP=3); ss/lc = press pulses; FSM registered:
//   IDLE: ss -> RUN; lc ignored.
//   RUN : ss -> STOP; lc -> LAP.
//   LAP : ss -> STOP; lc -> RUN.
//   STOP: ss -> RUN; lc -> IDLE.
//   ss and lc in same cycle: ss taken, lc discarded.
//  Outputs are registered decodes of the next state, so they change on the transition edge:
//   cnt_nclr = 0 iff state==IDLE; disp_hold = 1 iff state==LAP.
//   STOP->RUN releases nothing extra. LAP->STOP clears disp_hold (stopped value shown).
//  Prescaler: counts 0..DIV-1 only in RUN/LAP. Holds its value in STOP, so sub-tick
//   phase survives pause and resume. Forced to 0 in IDLE. cnt_en=1 for exactly the
//   one cycle where prescaler==DIV-1 in RUN/LAP, with wrap to 0 on the same edge.
//   First cnt_en after IDLE->RUN falls in the DIV-th RUN cycle.
//   Leaving RUN/LAP in the cycle prescaler==DIV-1 suppresses that pulse.
//  ovf: set on any clk edge where chain_cout==1 (chain wraps on that edge). Cleared
//   only in IDLE. The chain wraps to zero and keeps counting; there is no saturation.
//   chain_cout is only sampled, never gated into cnt_en, so there is no combinational loop.
//  Mid-run reset: everything returns to reset values immediately; counters are cleared via cnt_nclr=0.
// STRUCTURE
//  stopwatch_defs.vh: state codes ST_IDLE/ST_RUN/ST_STOP/ST_LAP, default DIV/DEB_CYCLES.
//  Sub-module key_press(clk, nclr, key_n, press), parameter DEB_CYCLES/DW, instantiated
//   twice. FSM, prescaler and ovf flag are inline in stopwatch_ctrl.
// TESTING (bench DIV=4, DEB_CYCLES=3; chain = three UniCounter-style digits)
//  Reset: after nclr=0 -> cnt_nclr=0, cnt_en=0, state=0, ovf=0; no press after release.
//  Bounce: key_ss toggles 1/0 every cycle for 10 cycles, then holds 0 -> exactly one ss
//   press, 2+3 cycles after the final stable 0 sample; state 0->1.
//  Run/pause: start, 10 ticks -> cnt_en pulses every 4 clk. Stop at prescaler=2, wait
//   20 clk with no cnt_en. Restart -> next cnt_en after 2 clk (phase kept).
//  Lap: in RUN, lc -> disp_hold=1 and cnt_en keeps pulsing. lc -> disp_hold=0, state=1.
//   ss in LAP -> state=2, disp_hold=0.
//  Clear + priority: in STOP, ss & lc pressed same cycle -> state=1 (lc dropped). Stop,
//   lc -> state=0, cnt_nclr=0 next edge, prescaler=0.
//  Overflow: digit chain at 999, one tick -> chain wraps to 000, ovf=1 stays set through
//   STOP. lc -> IDLE clears ovf.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch sequencer: state codes, default timing,
// and a helper telling which states let the prescaler run.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } state_t;

  localparam int DEF_DIV        = 500000;
  localparam int DEF_DEB_CYCLES = 250000;

  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/key_press.sv
// Push-button front end: two-flop synchroniser, level debouncer and a one-clock
// press pulse on each accepted 1->0 transition of the active-low key.
module key_press
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int DW         = 18
) (
  input  logic clk,
  input  logic nclr,
  input  logic key_n,
  output logic press
);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Any sample agreeing with the accepted level restarts the run of differing samples.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop/lap/clear FSM, tick prescaler for the digit
// chain, chain clear and display freeze, and the sticky overflow flag.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DIV        = DEF_DIV,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PW         = 19,
  parameter int DW         = 18
) (
  input  logic       clk,
  input  logic       nclr,
  input  logic       key_ss,
  input  logic       key_lc,
  input  logic       chain_cout,
  output logic       cnt_en,
  output logic       cnt_nclr,
  output logic       disp_hold,
  output logic       ovf,
  output logic [1:0] state
);

  logic          ss_press;
  logic          lc_press;
  state_t        state_q;
  state_t        state_d;
  logic          keep_counting;
  logic [PW-1:0] presc;

  key_press #(.DEB_CYCLES(DEB_CYCLES), .DW(DW)) u_key_ss (
    .clk   (clk),
    .nclr  (nclr),
    .key_n (key_ss),
    .press (ss_press)
  );

  key_press #(.DEB_CYCLES(DEB_CYCLES), .DW(DW)) u_key_lc (
    .clk   (clk),
    .nclr  (nclr),
    .key_n (key_lc),
    .press (lc_press)
  );

  // Start/stop wins over lap/clear when both presses land in the same cycle.
  always_comb begin
    state_d       = state_q;
    keep_counting = 1'b0;
    cnt_en        = 1'b0;
    unique case (state_q)
      ST_IDLE: if (ss_press) state_d = ST_RUN;
      ST_RUN: begin
        if (ss_press)      state_d = ST_STOP;
        else if (lc_press) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)      state_d = ST_STOP;
        else if (lc_press) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (ss_press)      state_d = ST_RUN;
        else if (lc_press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    keep_counting = is_counting(state_q) && is_counting(state_d);
    cnt_en        = keep_counting && (presc == PW'(DIV - 1));
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      state_q   <= ST_IDLE;
      cnt_nclr  <= 1'b0;
      disp_hold <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_nclr  <= (state_d != ST_IDLE);
      disp_hold <= (state_d == ST_LAP);
    end
  end

  // A cycle that leaves RUN/LAP does not advance the phase, so a pause keeps it exactly.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      presc <= '0;
    end else if (state_d == ST_IDLE) begin
      presc <= '0;
    end else if (keep_counting) begin
      presc <= cnt_en ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      ovf <= 1'b0;
    end else if (state_d == ST_IDLE) begin
      ovf <= 1'b0;
    end else if (chain_cout) begin
      ovf <= 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl driving a three-digit decimal chain model,
// with randomized key activity predicted by a sample-window reference model.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       nclr = 1'b0;
  logic       key_ss = 1'b1;
  logic       key_lc = 1'b1;
  logic       chain_cout;
  logic       cnt_en;
  logic       cnt_nclr;
  logic       disp_hold;
  logic       ovf;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int chain_val;

  typedef struct packed {
    logic [1:0] state;
    logic       cnt_en;
    logic       cnt_nclr;
    logic       disp_hold;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  stopwatch_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .PW(3), .DW(2)) dut (
    .clk        (clk),
    .nclr       (nclr),
    .key_ss     (key_ss),
    .key_lc     (key_lc),
    .chain_cout (chain_cout),
    .cnt_en     (cnt_en),
    .cnt_nclr   (cnt_nclr),
    .disp_hold  (disp_hold),
    .ovf        (ovf),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Three cascaded decimal digits seen as one 000..999 value; carry out on the wrap tick.
  always_ff @(posedge clk or negedge cnt_nclr) begin
    if (!cnt_nclr) chain_val <= 0;
    else if (cnt_en) chain_val <= (chain_val == 999) ? 0 : chain_val + 1;
  end
  assign chain_cout = cnt_en && (chain_val == 999);

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit running(input int m);
    return (m == 1) || (m == 3);
  endfunction

  function automatic int nxt(input int m, input bit ss, input bit lc);
    case (m)
      0: return ss ? 1 : 0;
      1: return ss ? 2 : (lc ? 3 : 1);
      3: return ss ? 2 : (lc ? 1 : 3);
      default: return ss ? 1 : (lc ? 0 : 2);
    endcase
  endfunction

  // Reference model: a key level flips once the last DEB synced samples all disagree with it.
  initial begin : model
    int mode = 0;
    int phase = 0;
    int count = 0;
    bit ovf_m = 0;
    bit lvl[2] = '{1'b1, 1'b1};
    bit prs[2] = '{1'b0, 1'b0};
    bit [DEB+1:0] hist[2] = '{'1, '1};
    bit raw[2];
    bit all_diff;
    int nm;
    exp_t e;
    forever begin
      @(posedge clk);
      if (!nclr) begin
        mode = 0; phase = 0; count = 0; ovf_m = 0;
        lvl = '{1'b1, 1'b1};
        prs = '{1'b0, 1'b0};
        hist = '{'1, '1};
      end else begin
        nm = nxt(mode, prs[0], prs[1]);
        if (nm == 0) begin
          phase = 0;
          count = 0;
        end else if (running(mode) && running(nm)) begin
          if (phase == DIV - 1) begin
            if (count == 999) ovf_m = 1;
            count = (count + 1) % 1000;
          end
          phase = (phase + 1) % DIV;
        end
        if (nm == 0) ovf_m = 0;
        mode = nm;
        raw[0] = key_ss;
        raw[1] = key_lc;
        for (int k = 0; k < 2; k++) begin
          hist[k] = {hist[k][DEB:0], raw[k]};
          all_diff = 1;
          for (int b = 2; b <= DEB + 1; b++) if (hist[k][b] == lvl[k]) all_diff = 0;
          prs[k] = 0;
          if (all_diff) begin
            lvl[k] = ~lvl[k];
            prs[k] = (lvl[k] == 0);
          end
        end
      end
      e.state     = 2'(mode);
      e.cnt_nclr  = (mode != 0);
      e.disp_hold = (mode == 3);
      e.ovf       = ovf_m;
      e.cnt_en    = running(mode) && running(nxt(mode, prs[0], prs[1])) && (phase == DIV - 1);
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("state",     int'(state),     int'(e.state));
        check_output("cnt_en",    int'(cnt_en),    int'(e.cnt_en));
        check_output("cnt_nclr",  int'(cnt_nclr),  int'(e.cnt_nclr));
        check_output("disp_hold", int'(disp_hold), int'(e.disp_hold));
        check_output("ovf",       int'(ovf),       int'(e.ovf));
      end
    end
  end

  task automatic apply_stimulus(input logic ss, input logic lc, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      key_ss = ss;
      key_lc = lc;
    end
  endtask

  task automatic press(input bit use_ss, input bit use_lc, input int bounce);
    logic v;
    for (int i = 0; i < bounce; i++) begin
      v = (i % 2 == 0) ? 1'b0 : 1'b1;
      apply_stimulus(use_ss ? v : 1'b1, use_lc ? v : 1'b1, 1);
    end
    apply_stimulus(~use_ss, ~use_lc, 6 + int'($urandom_range(0, 4)));
    apply_stimulus(1'b1, 1'b1, 8);
  endtask

  task automatic check_reset_outputs();
    check_output("rst_state",     int'(state),     0);
    check_output("rst_cnt_en",    int'(cnt_en),    0);
    check_output("rst_cnt_nclr",  int'(cnt_nclr),  0);
    check_output("rst_disp_hold", int'(disp_hold), 0);
    check_output("rst_ovf",       int'(ovf),       0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    key_ss = 1'b1;
    key_lc = 1'b1;
    nclr   = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    nclr = 1'b1;
  endtask

  initial begin : stimulus
    int op;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    #1;
    nclr = 1'b1;
    apply_stimulus(1'b1, 1'b1, 12);

    press(1'b1, 1'b0, 10);
    check_output("bounce_to_run", int'(state), 1);
    apply_stimulus(1'b1, 1'b1, 30);

    press(1'b0, 1'b1, 0);
    check_output("lap_hold", int'(disp_hold), 1);
    apply_stimulus(1'b1, 1'b1, 13);
    press(1'b0, 1'b1, 2);
    check_output("lap_back_run", int'(state), 1);
    press(1'b0, 1'b1, 0);
    apply_stimulus(1'b1, 1'b1, 5);
    press(1'b1, 1'b0, 0);
    check_output("lap_to_stop", int'(state), 2);
    apply_stimulus(1'b1, 1'b1, 20);
    press(1'b1, 1'b1, 0);
    check_output("both_keys_run", int'(state), 1);
    apply_stimulus(1'b1, 1'b1, 7);
    press(1'b1, 1'b0, 0);
    press(1'b0, 1'b1, 0);
    check_output("clear_idle", int'(state), 0);

    for (int n = 0; n < 50; n++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: press(1'b1, 1'b0, int'($urandom_range(0, 5)));
        1: press(1'b0, 1'b1, int'($urandom_range(0, 5)));
        2: press(1'b1, 1'b1, 0);
        default: apply_stimulus(1'b1, 1'b1, int'($urandom_range(1, 15)));
      endcase
    end

    do_reset();
    press(1'b1, 1'b0, 0);
    apply_stimulus(1'b1, 1'b1, 9);
    do_reset();
    apply_stimulus(1'b1, 1'b1, 10);

    press(1'b1, 1'b0, 0);
    apply_stimulus(1'b1, 1'b1, 4050);
    press(1'b1, 1'b0, 0);
    apply_stimulus(1'b1, 1'b1, 10);
    check_output("ovf_sticky_stop", int'(ovf), 1);
    check_output("ovf_state_stop", int'(state), 2);
    press(1'b0, 1'b1, 0);
    check_output("ovf_cleared", int'(ovf), 0);
    check_output("idle_chain_clr", int'(cnt_nclr), 0);

    apply_stimulus(1'b1, 1'b1, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
